vga_receiver: RTL and testbench

VGA_RECEIVER -- requirements
Module: vga_receiver

---
 rtl/vga_receiver.sv | 201 ++++++++++++++++++++
 tb/tb_vga_receiver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_receiver.sv
// VGA pixel capture front end: sync edge timing, frame lock FSM, and
// a small FIFO that hands pixels to a valid/ready stream sink.
module vga_receiver #(
    parameter int unsigned H_START    = 48,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_START    = 33,
    parameter int unsigned V_ACTIVE   = 480,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        io_clock,
    input  logic        io_reset,
    input  logic        io_enable,
    input  logic [2:0]  io_vga_pixels_r,
    input  logic [2:0]  io_vga_pixels_g,
    input  logic [1:0]  io_vga_pixels_b,
    input  logic        io_vga_hSync,
    input  logic        io_vga_vSync,
    output logic        io_pixel_valid,
    input  logic        io_pixel_ready,
    output logic [9:0]  io_pixel_payload,
    output logic        io_locked,
    output logic [11:0] io_lineLength,
    output logic [10:0] io_frameLines,
    output logic        io_overflow,
    input  logic        io_clearStatus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [11:0] H_MAX  = 12'hFFF;
    localparam logic [10:0] V_MAX  = 11'h7FF;
    localparam logic [11:0] H_LO   = 12'(H_START);
    localparam logic [11:0] H_HI   = 12'(H_START + H_ACTIVE);
    localparam logic [11:0] H_LAST = 12'(H_START + H_ACTIVE - 1);
    localparam logic [10:0] V_LO   = 11'(V_START);
    localparam logic [10:0] V_HI   = 11'(V_START + V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VSYNC,
        CAPTURE
    } state_t;

    logic [7:0]  pix_q;
    logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic        h_edge, v_edge;
    logic [11:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic [11:0] line_len_q, line_len_d;
    logic [10:0] frame_lines_q, frame_lines_d;
    state_t      state_q, state_d;
    logic        locked;
    logic        h_act, v_act;
    logic        wr_vld_q, wr_vld_d;
    logic [9:0]  wr_dat_q, wr_dat_d;
    logic [9:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        empty, full, push, pop, drop, flush;
    logic        ovf_q, ovf_d;

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            pix_q     <= '0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            hs_prev_q <= ~SYNC_POL;
            vs_prev_q <= ~SYNC_POL;
        end else begin
            pix_q     <= {io_vga_pixels_r, io_vga_pixels_g, io_vga_pixels_b};
            hs_q      <= io_vga_hSync;
            vs_q      <= io_vga_vSync;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
        end
    end

    assign h_edge = (hs_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
    assign v_edge = (vs_q == SYNC_POL) && (vs_prev_q != SYNC_POL);

    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        if (h_edge) begin
            hcnt_d     = '0;
            line_len_d = (hcnt_q == H_MAX) ? H_MAX : hcnt_q + 12'd1;
        end else if (hcnt_q != H_MAX) begin
            hcnt_d = hcnt_q + 12'd1;
        end
        // a frame edge wins over the coincident line edge
        if (v_edge) begin
            vcnt_d        = '0;
            frame_lines_d = (vcnt_q == V_MAX) ? V_MAX : vcnt_q + 11'd1;
        end else if (h_edge && vcnt_q != V_MAX) begin
            vcnt_d = vcnt_q + 11'd1;
        end
    end

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
        end
    end

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!io_enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:       state_d = WAIT_VSYNC;
                WAIT_VSYNC: if (v_edge) state_d = CAPTURE;
                CAPTURE:    state_d = CAPTURE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        locked = 1'b0;
        unique case (state_q)
            CAPTURE: locked = 1'b1;
            default: locked = 1'b0;
        endcase
    end

    assign h_act = (hcnt_q >= H_LO) && (hcnt_q < H_HI);
    assign v_act = (vcnt_q >= V_LO) && (vcnt_q < V_HI);

    always_comb begin
        wr_vld_d = io_enable && locked && h_act && v_act;
        wr_dat_d = {(hcnt_q == H_LO) && (vcnt_q == V_LO),
                    hcnt_q == H_LAST,
                    pix_q};
    end

    assign flush = !io_enable;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && io_pixel_ready;
    // a read frees the slot the write lands in, so full+read still accepts
    assign push  = wr_vld_q && (!full || pop);
    assign drop  = wr_vld_q && full && !pop && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
        ovf_d = (ovf_q && !io_clearStatus) || drop;
    end

    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            wr_vld_q <= 1'b0;
            wr_dat_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_vld_q <= wr_vld_d && !flush;
            wr_dat_q <= wr_dat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge io_clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_q;
    end

    assign io_pixel_valid   = !empty;
    assign io_pixel_payload = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign io_locked        = locked;
    assign io_lineLength    = line_len_q;
    assign io_frameLines    = frame_lines_q;
    assign io_overflow      = ovf_q;

endmodule

// File: tb/tb_vga_receiver.sv
// Bench for vga_receiver on a shrunken 20x8 raster with a pixel
// scoreboard, a phase table and hand-written corner sequences.
module tb_vga_receiver;

    localparam int HS    = 4;
    localparam int HA    = 10;
    localparam int VS    = 2;
    localparam int VA    = 4;
    localparam int LINE  = 20;
    localparam int NLINE = 8;
    localparam int DEPTH = 16;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        en = 0;
    logic        rdy = 1;
    logic        clr = 0;
    logic [2:0]  r = 0, g = 0;
    logic [1:0]  b = 0;
    logic        hs = 1, vs = 1;
    logic        valid, locked, ovf;
    logic [9:0]  payload;
    logic [11:0] ll;
    logic [10:0] fl;

    vga_receiver #(
        .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA),
        .SYNC_POL(1'b0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .io_clock(clk), .io_reset(rst_n), .io_enable(en),
        .io_vga_pixels_r(r), .io_vga_pixels_g(g), .io_vga_pixels_b(b),
        .io_vga_hSync(hs), .io_vga_vSync(vs),
        .io_pixel_valid(valid), .io_pixel_ready(rdy),
        .io_pixel_payload(payload), .io_locked(locked),
        .io_lineLength(ll), .io_frameLines(fl),
        .io_overflow(ovf), .io_clearStatus(clr)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         gx = 0, gy = 0;
    bit         cap = 0, hold = 0, manual = 0;
    int         hold_cnt = 0;
    logic       hs_man = 1;
    logic [9:0] exp_q[$];
    int         sof_k = 0;
    bit         sof_chk = 0;
    bit         held = 0;
    logic [9:0] held_pl = 0;

    typedef struct {
        bit en;
        bit rdy;
        int n;
        bit lk;
        int ll;
        int fl;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic logic [7:0] pix_of(int x, int y);
        if (x == HS + 1 && y == VS) return 8'hA5;
        return 8'((x * 7 + y * 13) & 255);
    endfunction

    task automatic step();
        logic [7:0] p;
        logic [9:0] e;
        bit act, keep;
        if (manual) begin
            hs = hs_man;
            vs = 1'b1;
            p  = 8'h00;
        end else begin
            hs = (gx < 2) ? 1'b0 : 1'b1;
            vs = (gy < 2) ? 1'b0 : 1'b1;
            p  = pix_of(gx, gy);
        end
        {r, g, b} = p;
        if (!manual && gx == 0 && gy == 0 && en && rst_n) cap = 1;
        if (!en || !rst_n) cap = 0;
        act = !manual && cap && gx >= HS + 1 && gx <= HS + HA &&
              gy >= VS && gy < VS + VA;
        @(posedge clk);
        cyc++;
        if (!rdy) sof_chk = 0;
        if (act) begin
            e = {gx == HS + 1 && gy == VS, gx == HS + HA, p};
            keep = 1;
            if (hold) begin
                hold_cnt++;
                if (hold_cnt > DEPTH) keep = 0;
            end
            if (keep) begin
                exp_q.push_back(e);
                if (e[9]) begin
                    sof_k   = cyc;
                    sof_chk = rdy;
                end
            end
        end
        if (!en || !rst_n) exp_q.delete();
        if (!manual) begin
            gx++;
            if (gx == LINE) begin
                gx = 0;
                gy++;
                if (gy == NLINE) gy = 0;
            end
        end
        #1;
    endtask

    task automatic run_to(int ty, int tx);
        int guard = 0;
        while (!(gy == ty && gx == tx) && guard < 2000) begin
            step();
            guard++;
        end
        if (guard >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL run_to: got position %0d,%0d, expected %0d,%0d",
                     gy, gx, ty, tx);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [9:0] e;
        if (rst_n && valid && rdy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pixel: got %0h, expected none",
                         payload);
            end else begin
                e = exp_q.pop_front();
                chk("payload", payload, e);
                if (e[9]) begin
                    chk("sof_payload_a5", payload, 10'h2A5);
                    if (sof_chk) chk("sof_latency", cyc, sof_k + 2);
                end
            end
        end
        if (valid && !rdy) begin
            if (held) chk("hold_stable", payload, held_pl);
            held    = 1;
            held_pl = payload;
        end else begin
            held = 0;
        end
    end

    initial begin
        tbl[0] = '{en: 0, rdy: 1, n: 40,  lk: 0, ll: 20, fl: 1};
        tbl[1] = '{en: 1, rdy: 1, n: 320, lk: 1, ll: 20, fl: 8};
        tbl[2] = '{en: 0, rdy: 1, n: 5,   lk: 0, ll: 20, fl: 8};
        tbl[3] = '{en: 1, rdy: 1, n: 5,   lk: 0, ll: 20, fl: 8};
        tbl[4] = '{en: 1, rdy: 1, n: 200, lk: 1, ll: 20, fl: 8};
        tbl[5] = '{en: 1, rdy: 0, n: 3,   lk: 1, ll: 20, fl: 8};
        tbl[6] = '{en: 1, rdy: 1, n: 50,  lk: 1, ll: 20, fl: 8};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_overflow", ovf, 0);
        chk("rst_lineLength", ll, 0);
        chk("rst_frameLines", fl, 0);
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            en  = tbl[i].en;
            rdy = tbl[i].rdy;
            repeat (tbl[i].n) step();
            chk($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
            chk($sformatf("tbl%0d_lineLength", i), ll, tbl[i].ll);
            chk($sformatf("tbl%0d_frameLines", i), fl, tbl[i].fl);
        end

        // enable dropped mid-line, then re-enabled before the next frame
        run_to(3, 9);
        chk("valid_before_drop", valid, 1);
        en = 0;
        step();
        chk("drop_valid", valid, 0);
        chk("drop_locked", locked, 0);
        repeat (10) step();
        en = 1;
        run_to(2, 0);
        chk("relock", locked, 1);

        // 20 active pixels against a stalled sink; clear races the drops
        rdy      = 0;
        hold     = 1;
        hold_cnt = 0;
        run_to(3, 13);
        clr = 1;
        run_to(3, 17);
        clr = 0;
        chk("ovf_clear_race", ovf, 1);
        run_to(4, 0);
        rdy  = 1;
        hold = 0;
        run_to(4, 3);
        chk("ovf_sticky", ovf, 1);
        clr = 1;
        step();
        clr = 0;
        chk("ovf_cleared", ovf, 0);

        // reset with buffered pixels
        run_to(2, 0);
        rdy = 0;
        run_to(2, 15);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_overflow", ovf, 0);
        chk("mid_rst_lineLength", ll, 0);
        chk("mid_rst_frameLines", fl, 0);
        chk("mid_rst_payload", payload, 0);
        exp_q.delete();
        cap = 0;
        step();
        step();
        rst_n = 1;
        rdy   = 1;
        run_to(2, 0);
        chk("post_rst_locked", locked, 1);
        run_to(6, 0);
        chk("queue_drained", exp_q.size(), 0);

        // hSync stuck asserted long enough to saturate the line counter
        en     = 0;
        manual = 1;
        hs_man = 0;
        repeat (5000) step();
        hs_man = 1;
        repeat (3) step();
        hs_man = 0;
        repeat (2) step();
        chk("sat_lineLength", ll, 12'hFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
